// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage RISC-V pipeline.
// Handles E-stage operand forwarding, load-use stalls and branch flushes.
// A small FSM holds multi-cycle execute ops (mul/div) in E.
// Saturating counters track stall and flush cycles.
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_AW-1:0]  Rs1D,
  input  logic [REG_AW-1:0]  Rs2D,
  input  logic [REG_AW-1:0]  Rs1E,
  input  logic [REG_AW-1:0]  Rs2E,
  input  logic [REG_AW-1:0]  RdE,
  input  logic [REG_AW-1:0]  RdM,
  input  logic [REG_AW-1:0]  RdW,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic               ResultSrcE,
  input  logic               PCSrcE,
  input  logic               McStartE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               StallF,
  output logic               StallD,
  output logic               StallE,
  output logic               FlushD,
  output logic               FlushE,
  output logic               FlushM,
  output logic               McBusy,
  output logic [COUNT_W-1:0] StallCount,
  output logic [COUNT_W-1:0] FlushCount
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // A latency of 1 means the op finishes in its single E cycle, so the FSM never engages.
  localparam logic       MC_EN   = (MC_LATENCY > 1);
  localparam logic [7:0] MC_LOAD = 8'(MC_LATENCY - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       lw_stall;
  logic       mc_stall;

  // Pick the forwarding source for one E-stage operand; M is newer so it wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (we_m && (rs == rd_m))      sel = 2'b10;
      else if (we_w && (rs == rd_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Raw hazard conditions; the multi-cycle hold outranks everything else.
  always_comb begin
    lw_stall = ResultSrcE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    mc_stall = ((state == IDLE) && McStartE && MC_EN) ||
               ((state == BUSY) && (cnt > 8'd1));
  end

  // Pipeline control outputs, all held inactive while reset is asserted.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    McBusy    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      StallF    = lw_stall || mc_stall;
      StallD    = lw_stall || mc_stall;
      StallE    = mc_stall;
      FlushM    = mc_stall;
      // A taken branch waits until the held op releases E before flushing.
      FlushD    = PCSrcE && !mc_stall;
      FlushE    = (lw_stall || PCSrcE) && !mc_stall;
      McBusy    = (state == BUSY);
    end
  end

  // Multi-cycle op FSM: cnt counts remaining E cycles after the first one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // McStartE is only honoured here; in BUSY the held op keeps driving it.
          if (McStartE && MC_EN) begin
            state <= BUSY;
            cnt   <= MC_LOAD;
          end
        end
        BUSY: begin
          if (cnt > 8'd1) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) StallCount <= StallCount + COUNT_W'(1);
      if (FlushD && (FlushCount != '1)) FlushCount <= FlushCount + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: a table of combinational vectors plus
// hand-written multi-cycle sequences. Three instances cover the default
// configuration, a 2-bit counter width and a latency of 1.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE;

  logic [1:0]  fa, fb;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m, s_busy;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [1:0]  l_fa, l_fb;
  logic        l_stall_f, l_stall_d, l_stall_e, l_flush_d, l_flush_e, l_flush_m, l_busy;
  logic [15:0] l_stall_cnt, l_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(4), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
    .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m), .McBusy(mc_busy),
    .StallCount(stall_cnt), .FlushCount(flush_cnt)
  );

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(4), .COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_stall_f), .StallD(s_stall_d), .StallE(s_stall_e),
    .FlushD(s_flush_d), .FlushE(s_flush_e), .FlushM(s_flush_m), .McBusy(s_busy),
    .StallCount(s_stall_cnt), .FlushCount(s_flush_cnt)
  );

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(1), .COUNT_W(16)) dut_l1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(l_fa), .ForwardBE(l_fb), .StallF(l_stall_f), .StallD(l_stall_d), .StallE(l_stall_e),
    .FlushD(l_flush_d), .FlushE(l_flush_e), .FlushM(l_flush_m), .McBusy(l_busy),
    .StallCount(l_stall_cnt), .FlushCount(l_flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, rsrc, pcsrc;
    logic [1:0] fa, fb;
    logic       stall, fld, fle;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 1'b0; PCSrcE = 1'b0; McStartE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Directed combinational vectors (no multi-cycle op in flight).
    //          rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc  fa     fb     st fd fe
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 1, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0};
    vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0};
    vecs[5]  = '{5'd0, 5'd0, 5'd4, 5'd6, 5'd0, 5'd4, 5'd6, 1, 1, 0, 0, 2'b10, 2'b01, 0, 0, 0};
    vecs[6]  = '{5'd0, 5'd0, 5'd4, 5'd6, 5'd0, 5'd4, 5'd6, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1};
    vecs[12] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 1};
    vecs[13] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0};

    // Reset state: every hazard-provoking input high, outputs must stay quiet.
    reset = 1'b1;
    clear_inputs();
    McStartE = 1'b1; PCSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; Rs2E = 5'd6; RdW = 5'd6; RegWriteW = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_fa", 32'(fa), 32'h0);
    chk("rst_fb", 32'(fb), 32'h0);
    chk("rst_stall", 32'({stall_f, stall_d, stall_e}), 32'h0);
    chk("rst_flush", 32'({flush_d, flush_e, flush_m}), 32'h0);
    chk("rst_busy", 32'(mc_busy), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;

    // Table-driven combinational checks.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc; McStartE = 1'b0;
      #1;
      chk($sformatf("vec%0d_fa", i), 32'(fa), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fb", i), 32'(fb), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_stallf", i), 32'(stall_f), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_stalld", i), 32'(stall_d), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_stalle", i), 32'(stall_e), 32'h0);
      chk($sformatf("vec%0d_flushd", i), 32'(flush_d), 32'(vecs[i].fld));
      chk($sformatf("vec%0d_flushe", i), 32'(flush_e), 32'(vecs[i].fle));
      chk($sformatf("vec%0d_flushm", i), 32'(flush_m), 32'h0);
    end

    // Load-use stall lasts one cycle and is counted once; RdE=0 never stalls.
    do_reset();
    @(negedge clk);
    ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk("lu_stallf", 32'(stall_f), 32'h1);
    chk("lu_stalld", 32'(stall_d), 32'h1);
    chk("lu_flushe", 32'(flush_e), 32'h1);
    chk("lu_stalle", 32'(stall_e), 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("lu_cnt", 32'(stall_cnt), 32'h1);
    chk("lu_release", 32'(stall_f), 32'h0);
    @(negedge clk);
    ResultSrcE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    chk("lu_x0_stallf", 32'(stall_f), 32'h0);
    chk("lu_x0_flushe", 32'(flush_e), 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("lu_x0_cnt", 32'(stall_cnt), 32'h1);

    // Single multi-cycle op with a branch and a forwarding match in E.
    do_reset();
    @(negedge clk);
    McStartE = 1'b1; PCSrcE = 1'b1; Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mc_c%0d_stallf", c), 32'(stall_f), 32'(c <= 3));
      chk($sformatf("mc_c%0d_stalle", c), 32'(stall_e), 32'(c <= 3));
      chk($sformatf("mc_c%0d_flushm", c), 32'(flush_m), 32'(c <= 3));
      chk($sformatf("mc_c%0d_flushd", c), 32'(flush_d), 32'(c == 4));
      chk($sformatf("mc_c%0d_flushe", c), 32'(flush_e), 32'(c == 4));
      chk($sformatf("mc_c%0d_busy", c), 32'(mc_busy), 32'(c >= 2));
      chk($sformatf("mc_c%0d_fa", c), 32'(fa), 32'h2);
      chk($sformatf("mc_c%0d_l1_stall", c), 32'(l_stall_f), 32'h0);
      chk($sformatf("mc_c%0d_l1_busy", c), 32'(l_busy), 32'h0);
      @(negedge clk);
    end
    clear_inputs();
    #1;
    chk("mc_end_busy", 32'(mc_busy), 32'h0);
    chk("mc_end_stallf", 32'(stall_f), 32'h0);
    chk("mc_stall_cnt", 32'(stall_cnt), 32'h3);
    chk("mc_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("mc_sat_cnt", 32'(s_stall_cnt), 32'h3);
    chk("mc_l1_cnt", 32'(l_stall_cnt), 32'h0);

    // Back-to-back ops: 3 stalls, 1 release, 3 stalls, 1 release.
    do_reset();
    @(negedge clk);
    McStartE = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("b2b_c%0d_stallf", c), 32'(stall_f), 32'((c % 4) != 3));
      chk($sformatf("b2b_c%0d_busy", c), 32'(mc_busy), 32'((c % 4) != 0));
      chk($sformatf("b2b_c%0d_l1_stall", c), 32'(l_stall_f), 32'h0);
      @(negedge clk);
    end
    clear_inputs();
    #1;
    chk("b2b_stall_cnt", 32'(stall_cnt), 32'h6);
    chk("b2b_sat_cnt", 32'(s_stall_cnt), 32'h3);
    chk("b2b_busy", 32'(mc_busy), 32'h0);
    chk("b2b_l1_cnt", 32'(l_stall_cnt), 32'h0);

    // Illegal load+multi-cycle combo, then reset in the second BUSY cycle.
    do_reset();
    @(negedge clk);
    McStartE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    chk("ill_stalle", 32'(stall_e), 32'h1);
    chk("ill_stallf", 32'(stall_f), 32'h1);
    chk("ill_flushe", 32'(flush_e), 32'h0);
    @(negedge clk);
    #1;
    chk("ab_busy1", 32'(mc_busy), 32'h1);
    @(negedge clk);
    #1;
    chk("ab_busy2", 32'(mc_busy), 32'h1);
    chk("ab_stall2", 32'(stall_f), 32'h1);
    reset = 1'b1;
    #1;
    chk("ab_rst_busy", 32'(mc_busy), 32'h0);
    chk("ab_rst_stall", 32'({stall_f, stall_d, stall_e, flush_m}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("ab_post_busy", 32'(mc_busy), 32'h0);
    chk("ab_post_stall", 32'({stall_f, stall_d, stall_e, flush_m}), 32'h0);
    chk("ab_post_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("ab_post_flush_cnt", 32'(flush_cnt), 32'h0);
    @(negedge clk);
    #1;
    chk("ab_post2_busy", 32'(mc_busy), 32'h0);
    chk("ab_post2_stall", 32'(stall_f), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Pipeline hazard controller for the 5-stage RISC-V core; successor to the single-cycle-execute hazard logic.
- Forwarding for E-stage operands from M and W.
- Load-use stall, with x0 and unused-destination filtering.
- Branch/jump flush.
- New: a counter-based state machine that holds a multi-cycle execute op (mul/div) in E for a parameterised latency while bubbling M.
- New: saturating stall and flush performance counters.

Parameters:
REG_AW, 5, register address width.
MC_LATENCY, 4, total cycles a multi-cycle op occupies E (legal range 1..255; 1 disables the FSM).
COUNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
Rs1D, Rs2D  in  REG_AW  source registers of the D-stage instruction.
Rs1E, Rs2E, RdE  in  REG_AW  source/destination registers of the E-stage instruction.
RdM, RdW  in  REG_AW  destinations in M and W.
RegWriteM, RegWriteW  in  1  M/W instructions write the register file.
ResultSrcE  in  1  E-stage instruction is a load.
PCSrcE  in  1  branch taken / jump in E.
McStartE  in  1  E-stage instruction is a multi-cycle op.
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result.
StallF, StallD, StallE  out  1  hold the PC, D register and E register.
FlushD, FlushE, FlushM  out  1  bubble the D, E and M registers.
McBusy  out  1  FSM in BUSY.
StallCount, FlushCount  out  COUNT_W  performance counters.

Behaviour:
Reset
- While reset=1 at a clock edge: state<=IDLE, cnt<=0, both counters<=0.
- While reset is high, all stall/flush outputs and McBusy are forced 0, and ForwardAE/BE are forced 00.
- Reset mid-BUSY aborts the op; no stall is asserted in the cycle after reset deasserts.

Forwarding (combinational, zero latency)
- ForwardAE=10 if Rs1E==RdM, RegWriteM=1 and Rs1E!=0.
- Else ForwardAE=01 if Rs1E==RdW, RegWriteW=1 and Rs1E!=0.
- Else ForwardAE=00.
- M has priority over W.
- ForwardBE follows the same rules using Rs2E.
- Forwarding stays active while E is held.

Load-use stall (lwStall)
- lwStall = ResultSrcE & (RdE!=0) & ((Rs1D==RdE) | (Rs2D==RdE)).
- Lasts 1 cycle.

Multi-cycle FSM (states IDLE, BUSY; cnt is 8-bit)
- IDLE and McStartE=1 and MC_LATENCY>1: go to BUSY, cnt<=MC_LATENCY-1.
- BUSY and cnt>1: cnt<=cnt-1.
- BUSY and cnt==1: go to IDLE, cnt<=0. The op leaves E at the next edge.
- McStartE is ignored in BUSY, because the held instruction still drives it.
- McStall = (IDLE & McStartE & MC_LATENCY>1) | (BUSY & cnt>1).
- The op occupies E for exactly MC_LATENCY cycles, with MC_LATENCY-1 stall cycles.
- Back-to-back multi-cycle ops restart from IDLE the cycle after the first op completes.

Output equations
- StallF = StallD = lwStall | McStall.
- StallE = FlushM = McStall.
- FlushD = PCSrcE & ~McStall.
- FlushE = (lwStall | PCSrcE) & ~McStall.
- McBusy = (state==BUSY).

Illegal combinations and priority
- ResultSrcE and McStartE both high is illegal; McStall takes priority and lwStall is ignored.
- PCSrcE during McStall is suppressed until the stall releases.

Counters (saturating at all-ones)
- StallCount increments on each edge where StallF=1.
- FlushCount increments on each edge where FlushD=1.

Test Plan:
- Forwarding priority: Rs1E=5, RdM=5, RdW=5, both RegWrite=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then Rs1E=0 -> ForwardAE=00.
- Load-use: ResultSrcE=1, RdE=7, Rs2D=7 -> one cycle with StallF=StallD=FlushE=1, StallE=0, StallCount=1. Repeat with RdE=0 -> no stall.
- Multi-cycle op, MC_LATENCY=4: McStartE held high for 4 cycles -> StallF/D/E and FlushM high for exactly 3 cycles; McBusy high on cycles 2-4; StallCount=3; state IDLE after the 4th edge.
- Back-to-back multi-cycle ops: two consecutive multi-cycle ops -> 3 stall cycles, 1 release cycle, then 3 more stall cycles.
- PCSrcE=1 during McStall -> FlushD=FlushE=0. PCSrcE=1 with no McStall -> FlushD=FlushE=1 and FlushCount increments.
- Reset in the 2nd BUSY cycle -> next cycle McBusy=0, all stalls 0, counters 0.
- Saturation, COUNT_W=2: 5 stall cycles -> StallCount=3.
- MC_LATENCY=1: McStartE=1 -> no stall ever.
